// File: rtl/usart_pkg.sv
// Shared definitions for the USART serial path (used by both the RX and TX sides).
package usart_pkg;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;
    localparam int MAX_DATA_BITS    = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } usart_state_t;

    // Narrower words are zero-extended by the caller, which leaves the parity unchanged.
    function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] data);
        return ^data;
    endfunction
endpackage

// File: rtl/usart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level (1).
module usart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_line,
    output logic sync_line
);
    logic sync1_reg;
    logic sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= async_line;
            sync2_reg <= sync1_reg;
        end
    end

    assign sync_line = sync2_reg;
endmodule

// File: rtl/usart_rx.sv
// UART receiver: start-bit validation, mid-bit sampling, optional even parity,
// and a one-entry holding register with a VALID/ACK handshake.
module usart_rx
    import usart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int PARITY_EN    = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RX_IN,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    input  logic                 RX_ACK,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
);
    localparam int H     = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic line;

    usart_state_t state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic perr_reg;

    logic shift_en;
    logic parity_en;
    logic stop_en;

    logic [DATA_BITS-1:0] data_reg;
    logic valid_reg;
    logic ferr_reg;
    logic perr_hold_reg;
    logic ovr_reg;

    usart_rx_sync u_sync (
        .clk        (CLK),
        .rst_n      (RESET),
        .async_line (RX_IN),
        .sync_line  (line)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Every sampling state clears the counter at its sample point, so it never wraps.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        idx_next   = idx_reg;
        shift_en   = 1'b0;
        parity_en  = 1'b0;
        stop_en    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (!line) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt_reg == CNT_MID) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_reg == CNT_END) begin
                    cnt_next = '0;
                    shift_en = 1'b1;
                    idx_next = idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_LAST) begin
                        state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_reg == CNT_END) begin
                    cnt_next   = '0;
                    parity_en  = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_reg == CNT_END) begin
                    cnt_next   = '0;
                    stop_en    = 1'b1;
                    state_next = line ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                cnt_next = '0;
                if (line) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            perr_reg  <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            idx_reg <= idx_next;
            if (shift_en) begin
                shift_reg <= {line, shift_reg[DATA_BITS-1:1]};
            end
            if (parity_en) begin
                perr_reg <= even_parity(MAX_DATA_BITS'(shift_reg)) ^ line;
            end
        end
    end

    // A load on the stop edge takes priority over an ACK arriving on the same edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            ferr_reg      <= 1'b0;
            perr_hold_reg <= 1'b0;
            ovr_reg       <= 1'b0;
        end else if (stop_en) begin
            if (!valid_reg || RX_ACK) begin
                data_reg      <= shift_reg;
                ferr_reg      <= !line;
                perr_hold_reg <= perr_reg;
                valid_reg     <= 1'b1;
            end else begin
                ovr_reg <= 1'b1;
            end
        end else if (valid_reg && RX_ACK) begin
            valid_reg     <= 1'b0;
            ferr_reg      <= 1'b0;
            perr_hold_reg <= 1'b0;
            ovr_reg       <= 1'b0;
        end
    end

    assign RX_DATA    = data_reg;
    assign RX_VALID   = valid_reg;
    assign FRAME_ERR  = ferr_reg;
    assign PARITY_ERR = perr_hold_reg;
    assign OVERRUN    = ovr_reg;
    assign BUSY       = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_usart_rx.sv
// Bench for usart_rx: an 8N1/16x instance and a 7E1/8x instance checked every cycle against a frame-level model.
module tb_usart_rx;
    localparam int CPB0 = 16, DB0 = 8, PE0 = 0;
    localparam int CPB1 = 8,  DB1 = 7, PE1 = 1;
    localparam int INF  = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [1:0] rx_line = 2'b11;
    logic [1:0] ack_s = 2'b00;
    logic [1:0] rdone = 2'b00;

    wire [7:0] d0;
    wire [6:0] d1;
    wire [1:0] valid_s, ferr_s, perr_s, ovr_s, busy_s;

    always #5 clk = ~clk;

    usart_rx #(.CLKS_PER_BIT(CPB0), .DATA_BITS(DB0), .PARITY_EN(PE0)) dut0 (
        .CLK(clk), .RESET(rst_n), .RX_IN(rx_line[0]), .RX_DATA(d0), .RX_VALID(valid_s[0]),
        .RX_ACK(ack_s[0]), .FRAME_ERR(ferr_s[0]), .PARITY_ERR(perr_s[0]), .OVERRUN(ovr_s[0]),
        .BUSY(busy_s[0])
    );

    usart_rx #(.CLKS_PER_BIT(CPB1), .DATA_BITS(DB1), .PARITY_EN(PE1)) dut1 (
        .CLK(clk), .RESET(rst_n), .RX_IN(rx_line[1]), .RX_DATA(d1), .RX_VALID(valid_s[1]),
        .RX_ACK(ack_s[1]), .FRAME_ERR(ferr_s[1]), .PARITY_ERR(perr_s[1]), .OVERRUN(ovr_s[1]),
        .BUSY(busy_s[1])
    );

    // Frame-level model: holding register plus one pending load and one busy window per instance.
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int m_data[2];
    bit m_valid[2], m_ferr[2], m_perr[2], m_ovr[2];
    bit pv[2], pf[2], pp[2];
    int pc[2], pd[2], bf[2], bt[2], last_t0[2];

    function automatic int cpb(input int i);
        return (i == 0) ? CPB0 : CPB1;
    endfunction
    function automatic int dbits(input int i);
        return (i == 0) ? DB0 : DB1;
    endfunction
    function automatic int pen(input int i);
        return (i == 0) ? PE0 : PE1;
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", name, i, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_data[i] = 0; m_valid[i] = 0; m_ferr[i] = 0; m_perr[i] = 0; m_ovr[i] = 0;
                pv[i] = 0; bt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pv[i] && pc[i] == cyc + 1) begin
                    pv[i] = 0;
                    if (!m_valid[i] || ack_s[i]) begin
                        m_data[i] = pd[i]; m_ferr[i] = pf[i]; m_perr[i] = pp[i]; m_valid[i] = 1;
                    end else begin
                        m_ovr[i] = 1;
                    end
                end else if (m_valid[i] && ack_s[i]) begin
                    m_valid[i] = 0; m_ferr[i] = 0; m_perr[i] = 0; m_ovr[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check("RX_DATA", i, (i == 0) ? 32'(d0) : 32'(d1), 32'(m_data[i]));
            check("RX_VALID", i, 32'(valid_s[i]), 32'(m_valid[i]));
            check("FRAME_ERR", i, 32'(ferr_s[i]), 32'(m_ferr[i]));
            check("PARITY_ERR", i, 32'(perr_s[i]), 32'(m_perr[i]));
            check("OVERRUN", i, 32'(ovr_s[i]), 32'(m_ovr[i]));
            check("BUSY", i, 32'(busy_s[i]), 32'(cyc >= bf[i] && cyc < bt[i]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic hold(input int i, input logic v);
        rx_line[i] = v;
        repeat (cpb(i)) tick();
    endtask

    task automatic send_frame(input int i, input logic [8:0] data, input logic pbit, input logic stop_bit);
        int n, t0;
        logic [8:0] dm;
        n = dbits(i);
        dm = data & 9'((1 << n) - 1);
        t0 = cyc + 1;
        last_t0[i] = t0;
        pc[i] = t0 + 2 + cpb(i) / 2 + (n + pen(i) + 1) * cpb(i);
        pd[i] = int'(dm);
        pf[i] = !stop_bit;
        pp[i] = (pen(i) != 0) ? ((^dm) ^ pbit) : 1'b0;
        pv[i] = 1;
        bf[i] = t0 + 2;
        bt[i] = stop_bit ? pc[i] : INF;
        hold(i, 1'b0);
        for (int b = 0; b < n; b++) hold(i, dm[b]);
        if (pen(i) != 0) hold(i, pbit);
        hold(i, stop_bit);
    endtask

    task automatic raise(input int i);
        rx_line[i] = 1'b1;
        bt[i] = cyc + 3;
        repeat (4) tick();
    endtask

    task automatic glitch(input int i, input int len);
        int t0;
        t0 = cyc + 1;
        bf[i] = t0 + 2;
        bt[i] = t0 + 2 + cpb(i) / 2;
        rx_line[i] = 1'b0;
        repeat (len) tick();
        rx_line[i] = 1'b1;
        repeat (cpb(i) / 2 + 4) tick();
    endtask

    task automatic ack_pulse(input int i);
        ack_s[i] = 1'b1;
        tick();
        ack_s[i] = 1'b0;
    endtask

    task automatic rand_traffic(input int i, input int frames);
        for (int f = 0; f < frames; f++) begin
            int r;
            logic [8:0] dat;
            logic pb, sb;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                glitch(i, int'($urandom_range(1, 32'(cpb(i) / 2))));
            end else begin
                dat = 9'($urandom);
                pb = 1'($urandom_range(0, 1));
                sb = (r != 1);
                send_frame(i, dat, pb, sb);
                if (!sb) begin
                    repeat ($urandom_range(0, 20)) tick();
                    raise(i);
                end
            end
            repeat ($urandom_range(0, 12)) tick();
        end
    endtask

    task automatic rand_ack(input int i);
        while (!rdone[i]) begin
            ack_s[i] = ($urandom_range(0, 5) == 0);
            tick();
        end
        ack_s[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("reset_valid", 0, 32'(valid_s[0]), 32'h0);
        check("reset_data", 0, 32'(d0), 32'h0);
        check("reset_busy", 0, 32'(busy_s[0]), 32'h0);

        // 0xA5, 8N1: BUSY from t0+2, RX_VALID after edge t0+154
        fork
            send_frame(0, 9'h0A5, 1'b0, 1'b1);
            begin
                #2;
                t = last_t0[0];
                wait_until(t + 1);
                check("busy_t0p1", 0, 32'(busy_s[0]), 32'h0);
                tick();
                check("busy_t0p2", 0, 32'(busy_s[0]), 32'h1);
                wait_until(t + 153);
                check("valid_t0p153", 0, 32'(valid_s[0]), 32'h0);
                tick();
                check("valid_t0p154", 0, 32'(valid_s[0]), 32'h1);
                check("data_a5", 0, 32'(d0), 32'hA5);
                check("ferr_a5", 0, 32'(ferr_s[0]), 32'h0);
                check("ovr_a5", 0, 32'(ovr_s[0]), 32'h0);
            end
        join

        // Reset while 0x5A is in its data bits
        t = cyc + 1;
        bf[0] = t + 2;
        bt[0] = INF;
        hold(0, 1'b0);
        hold(0, 1'b0);
        hold(0, 1'b1);
        check("busy_mid", 0, 32'(busy_s[0]), 32'h1);
        #3 rst_n = 1'b0;
        rx_line[0] = 1'b1;
        #1;
        check("rst_valid", 0, 32'(valid_s[0]), 32'h0);
        check("rst_data", 0, 32'(d0), 32'h0);
        check("rst_busy", 0, 32'(busy_s[0]), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        send_frame(0, 9'h05A, 1'b0, 1'b1);
        check("data_5a", 0, 32'(d0), 32'h5A);
        check("valid_5a", 0, 32'(valid_s[0]), 32'h1);
        ack_pulse(0);
        check("ack_valid", 0, 32'(valid_s[0]), 32'h0);
        check("ack_data_hold", 0, 32'(d0), 32'h5A);

        // Short low pulse is rejected at the start-bit mid-sample
        glitch(0, 4);
        check("glitch_valid", 0, 32'(valid_s[0]), 32'h0);
        check("glitch_busy", 0, 32'(busy_s[0]), 32'h0);

        // Stop bit 0 with the line held low: framing error, then WAIT_IDLE
        send_frame(0, 9'h03C, 1'b0, 1'b0);
        check("data_3c", 0, 32'(d0), 32'h3C);
        check("ferr_3c", 0, 32'(ferr_s[0]), 32'h1);
        repeat (40) tick();
        check("busy_wait_idle", 0, 32'(busy_s[0]), 32'h1);
        raise(0);
        check("busy_after_raise", 0, 32'(busy_s[0]), 32'h0);
        repeat (200) tick();
        check("no_second_frame", 0, 32'(d0), 32'h3C);
        check("valid_3c_held", 0, 32'(valid_s[0]), 32'h1);
        ack_pulse(0);
        check("ferr_cleared", 0, 32'(ferr_s[0]), 32'h0);

        // Back-to-back frames without ACK: overrun keeps the first word
        send_frame(0, 9'h001, 1'b0, 1'b1);
        send_frame(0, 9'h002, 1'b0, 1'b1);
        check("data_01", 0, 32'(d0), 32'h01);
        check("ovr_set", 0, 32'(ovr_s[0]), 32'h1);
        ack_pulse(0);
        check("ovr_valid_clr", 0, 32'(valid_s[0]), 32'h0);
        check("ovr_clr", 0, 32'(ovr_s[0]), 32'h0);
        send_frame(0, 9'h003, 1'b0, 1'b1);
        check("data_03", 0, 32'(d0), 32'h03);
        fork
            send_frame(0, 9'h004, 1'b0, 1'b1);
            begin
                #2;
                t = pc[0];
                wait_until(t - 1);
                ack_pulse(0);
            end
        join
        check("ack_load_valid", 0, 32'(valid_s[0]), 32'h1);
        check("ack_load_data", 0, 32'(d0), 32'h04);
        ack_pulse(0);

        // Even parity on the 7E1 instance
        send_frame(1, 9'h007, 1'b0, 1'b1);
        check("perr_bad", 1, 32'(perr_s[1]), 32'h1);
        check("data_07", 1, 32'(d1), 32'h07);
        ack_pulse(1);
        send_frame(1, 9'h007, 1'b1, 1'b1);
        check("perr_good", 1, 32'(perr_s[1]), 32'h0);
        check("valid_07", 1, 32'(valid_s[1]), 32'h1);
        ack_pulse(1);

        // Randomized traffic with random ACKs on both instances
        fork
            begin rand_traffic(0, 30); rdone[0] = 1'b1; end
            begin rand_traffic(1, 50); rdone[1] = 1'b1; end
            rand_ack(0);
            rand_ack(1);
        join
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/usart_rx.md
Name: usart_rx

Overview:
- Serial receiver (UART/USART RX) that consumes the conditioned TX_OUT line produced by the logic-input stage of the USART path.
- Synchronises the line, detects and validates the start bit, and mid-bit samples DATA_BITS data bits LSB-first, an optional even-parity bit and one stop bit.
- Presents each byte in a one-entry holding register with a VALID/ACK handshake to the consumer.

Parameters:
- CLKS_PER_BIT, 16, CLK cycles per serial bit; even, >=4. H = CLKS_PER_BIT/2.
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY_EN, 0, 1 = expect an even-parity bit after the data bits.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line, idle high; driven from TX_OUT.
- RX_DATA  out  DATA_BITS  received word, first-received bit in bit 0.
- RX_VALID  out  1  holding register full.
- RX_ACK  in  1  consumer pops the holding register.
- FRAME_ERR  out  1  stop bit sampled 0 for the held word.
- PARITY_ERR  out  1  parity mismatch for the held word (always 0 if PARITY_EN=0).
- OVERRUN  out  1  a frame completed while the holding register was full.
- BUSY  out  1  FSM not in IDLE.

Behaviour:
- Reset (RESET=0, asynchronous):
  - All outputs 0, RX_DATA=0.
  - Synchroniser flops = 1.
  - FSM = IDLE; counters = 0.
- Input synchronisation: 2-flop synchroniser on RX_IN; the FSM sees only the output sync2.
- Timing reference: t0 = first CLK edge at which RX_IN is sampled 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: sync2=0 -> START, cnt=0 (edge t0+2).
  - START:
    - cnt increments each cycle; the start bit is sampled when cnt==H-1 (edge t0+2+H).
    - Sample 0 -> DATA, cnt=0, bit index=0.
    - Sample 1 -> IDLE (glitch reject; no flags, no output change).
  - DATA: sample when cnt==CLKS_PER_BIT-1, then cnt=0. Slot k is sampled at edge t0+2+H+k*CLKS_PER_BIT.
    - Shift the sample into the MSB of the shift register (LSB-first line order).
    - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
  - PARITY: sample one bit; perr = (XOR of data bits XOR sample) != 0. -> STOP.
  - STOP: at mid-bit sample, perform the load (rules below).
    - Sample 1 -> IDLE.
    - Sample 0 -> WAIT_IDLE (prevents a break being taken as a new start bit).
  - WAIT_IDLE: stays until sync2=1, then -> IDLE.
- Load at the stop-sample edge (single edge, registered):
  - If RX_VALID=0, or RX_ACK=1 in the same cycle:
    - RX_DATA <= shift register; FRAME_ERR <= !stop; PARITY_ERR <= perr; RX_VALID <= 1.
  - Else (register full, no ACK): OVERRUN <= 1. The held word and its flags are kept; the new frame is dropped.
  - Errored frames are still loaded, with their flags set.
- Latency: with PARITY_EN=0, RX_VALID rises after edge t0+2+H+(DATA_BITS+1)*CLKS_PER_BIT.
  - Defaults: t0+154.
- Handshake:
  - RX_ACK with RX_VALID=1 and no simultaneous load: RX_VALID, FRAME_ERR and PARITY_ERR clear next edge; RX_DATA holds its value.
  - RX_ACK with RX_VALID=0 is ignored.
  - OVERRUN is sticky; it clears on any accepted RX_ACK.
  - Simultaneous load and ACK: the load wins, RX_VALID stays 1, OVERRUN is unaffected.
- Counter widths: cnt is $clog2(CLKS_PER_BIT) bits; bit index is $clog2(DATA_BITS+1) bits. The counter never wraps inside a state, because every state resets it at its sample point.
- Reset mid-frame: the frame is abandoned. After release, reception resumes at the next falling edge seen in IDLE.
  - A partial frame still on the line is treated as ordinary line activity: it is glitch-rejected or received as garbage (framing error likely).

Decomposition:
- usart_pkg: FSM state enum, default CLKS_PER_BIT/DATA_BITS constants, parity helper function. Shared with the TX side.
- One sub-module: usart_rx_sync (2-flop synchroniser, reset value 1, async active-low reset).
- The FSM, counters, shift register and holding register live in usart_rx.

Test Plan:
1. Reset: RESET=0 mid-frame (during DATA) -> all outputs 0 at once; after release, a clean 0x5A frame -> RX_DATA=0x5A, RX_VALID=1.
2. 0xA5 frame, 8N1, 16 clk/bit -> RX_VALID rises after edge t0+154; RX_DATA=0xA5; FRAME_ERR=0, OVERRUN=0; BUSY=1 from t0+2.
3. RX_IN low for 4 cycles, then high -> START rejects at the mid-sample, FSM returns to IDLE, RX_VALID stays 0, no flags.
4. 0x3C frame with stop bit 0 and line held low 40 more cycles -> RX_DATA=0x3C, FRAME_ERR=1; FSM in WAIT_IDLE until the line goes high; no spurious second frame.
5. Back-to-back frames 0x01, 0x02 without ACK -> RX_DATA=0x01, OVERRUN=1. RX_ACK -> RX_VALID=0, OVERRUN=0. Then 0x03 -> RX_DATA=0x03. Also: ACK on the same edge as a load -> RX_VALID stays 1 with the new data.
6. PARITY_EN=1, data 0x07 with parity bit 0 -> PARITY_ERR=1. The same data with parity bit 1 -> PARITY_ERR=0.
